instr_imm_encoder: RTL

- Inverse of the datapath's immediate sign-extender: packs a 64-bit signed immediate and register/function fields into a 32-bit RV64 instruction word for I, S, SB, U and UJ formats.
- Checks that the immediate is representable in the chosen format.
- Two-stage valid/ready pipeline; feeds the self-test instruction loader that writes generated programs into instruction memory.
- Round-trip invariant: sign-extender(out_instr) == in_imm whenever out_err = 0.

---
 rtl/riscv_enc_pkg.sv | 39 +++
 rtl/imm_pack.sv | 62 ++++++
 rtl/instr_imm_encoder.sv | 122 ++++++++++++
 3 files changed

// File: rtl/riscv_enc_pkg.sv
// Shared formats, opcodes and immediate limits for the RV64 instruction encoder.
// Limits are signed 64-bit so range checks are plain comparisons.
package riscv_enc_pkg;

    typedef enum logic [2:0] {
        FMT_I  = 3'd0,
        FMT_S  = 3'd1,
        FMT_SB = 3'd2,
        FMT_U  = 3'd3,
        FMT_UJ = 3'd4
    } fmt_t;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic signed [63:0] IMM_I_MIN  = -64'sd2048;
    localparam logic signed [63:0] IMM_I_MAX  = 64'sd2047;
    localparam logic signed [63:0] IMM_SB_MIN = -64'sd4096;
    localparam logic signed [63:0] IMM_SB_MAX = 64'sd4094;
    localparam logic signed [63:0] IMM_UJ_MIN = -64'sd1048576;
    localparam logic signed [63:0] IMM_UJ_MAX = 64'sd1048574;
    localparam logic signed [63:0] IMM_U_MIN  = -64'sd2147483648;
    localparam logic signed [63:0] IMM_U_MAX  = 64'sd2147483647;

    function automatic logic in_range(
        input logic signed [63:0] v,
        input logic signed [63:0] lo,
        input logic signed [63:0] hi
    );
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/imm_pack.sv
// Combinational packer: range-checks the immediate and scatters it into
// the instruction word for the selected format.
import riscv_enc_pkg::*;

module imm_pack (
    input  logic [2:0]  i_fmt,
    input  logic [6:0]  i_opcode,
    input  logic [4:0]  i_rd,
    input  logic [4:0]  i_rs1,
    input  logic [4:0]  i_rs2,
    input  logic [2:0]  i_funct3,
    input  logic [63:0] i_imm,
    output logic [31:0] o_instr,
    output logic        o_err
);

    logic signed [63:0] w_imm;
    logic               w_ok;
    logic [31:0]        w_word;

    assign w_imm = i_imm;

    always_comb begin
        w_ok   = 1'b0;
        w_word = '0;
        case (i_fmt)
            FMT_I: begin
                w_ok   = in_range(w_imm, IMM_I_MIN, IMM_I_MAX);
                w_word = {i_imm[11:0], i_rs1, i_funct3, i_rd, i_opcode};
            end
            FMT_S: begin
                w_ok   = in_range(w_imm, IMM_I_MIN, IMM_I_MAX);
                w_word = {i_imm[11:5], i_rs2, i_rs1, i_funct3,
                          i_imm[4:0], i_opcode};
            end
            FMT_SB: begin
                w_ok   = in_range(w_imm, IMM_SB_MIN, IMM_SB_MAX) && !i_imm[0];
                w_word = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3,
                          i_imm[4:1], i_imm[11], i_opcode};
            end
            FMT_U: begin
                // Low 12 bits must be zero; range pins bits 63:31 to the sign.
                w_ok   = in_range(w_imm, IMM_U_MIN, IMM_U_MAX)
                         && (i_imm[11:0] == 12'd0);
                w_word = {i_imm[31:12], i_rd, i_opcode};
            end
            FMT_UJ: begin
                w_ok   = in_range(w_imm, IMM_UJ_MIN, IMM_UJ_MAX) && !i_imm[0];
                w_word = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12],
                          i_rd, i_opcode};
            end
            default: begin
                w_ok   = 1'b0;
                w_word = '0;
            end
        endcase
    end

    assign o_err   = !w_ok;
    assign o_instr = w_ok ? w_word : 32'h0;

endmodule

// File: rtl/instr_imm_encoder.sv
// Two-stage valid/ready encoder: S1 holds the request, S2 holds the packed
// word; saturating counters track emitted good and rejected words.
import riscv_enc_pkg::*;

module instr_imm_encoder #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_fmt,
    input  logic [6:0]       in_opcode,
    input  logic [4:0]       in_rd,
    input  logic [4:0]       in_rs1,
    input  logic [4:0]       in_rs2,
    input  logic [2:0]       in_funct3,
    input  logic [63:0]      in_imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic             out_err,
    output logic [CNT_W-1:0] cnt_ok,
    output logic [CNT_W-1:0] cnt_err
);

    logic             r_s1_valid;
    logic [2:0]       r_s1_fmt;
    logic [6:0]       r_s1_opcode;
    logic [4:0]       r_s1_rd;
    logic [4:0]       r_s1_rs1;
    logic [4:0]       r_s1_rs2;
    logic [2:0]       r_s1_funct3;
    logic [63:0]      r_s1_imm;
    logic             r_s2_valid;
    logic [31:0]      r_s2_instr;
    logic             r_s2_err;
    logic [CNT_W-1:0] r_cnt_ok;
    logic [CNT_W-1:0] r_cnt_err;

    logic        w_s2_adv;
    logic        w_s1_adv;
    logic        w_accept;
    logic        w_emit;
    logic [31:0] w_instr;
    logic        w_err;

    assign w_s2_adv = !r_s2_valid || out_ready;
    assign w_s1_adv = !r_s1_valid || w_s2_adv;
    assign w_accept = in_valid && w_s1_adv;
    assign w_emit   = r_s2_valid && out_ready;

    imm_pack u_pack (
        .i_fmt    (r_s1_fmt),
        .i_opcode (r_s1_opcode),
        .i_rd     (r_s1_rd),
        .i_rs1    (r_s1_rs1),
        .i_rs2    (r_s1_rs2),
        .i_funct3 (r_s1_funct3),
        .i_imm    (r_s1_imm),
        .o_instr  (w_instr),
        .o_err    (w_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid  <= 1'b0;
            r_s1_fmt    <= '0;
            r_s1_opcode <= '0;
            r_s1_rd     <= '0;
            r_s1_rs1    <= '0;
            r_s1_rs2    <= '0;
            r_s1_funct3 <= '0;
            r_s1_imm    <= '0;
        end else if (w_s1_adv) begin
            r_s1_valid <= in_valid;
            if (w_accept) begin
                r_s1_fmt    <= in_fmt;
                r_s1_opcode <= in_opcode;
                r_s1_rd     <= in_rd;
                r_s1_rs1    <= in_rs1;
                r_s1_rs2    <= in_rs2;
                r_s1_funct3 <= in_funct3;
                r_s1_imm    <= in_imm;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_s2_instr <= '0;
            r_s2_err   <= 1'b0;
        end else if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_instr <= w_instr;
                r_s2_err   <= w_err;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt_ok  <= '0;
            r_cnt_err <= '0;
        end else if (w_emit) begin
            if (!r_s2_err && !(&r_cnt_ok))
                r_cnt_ok <= r_cnt_ok + CNT_W'(1);
            if (r_s2_err && !(&r_cnt_err))
                r_cnt_err <= r_cnt_err + CNT_W'(1);
        end
    end

    assign in_ready  = w_s1_adv;
    assign out_valid = r_s2_valid;
    assign out_instr = r_s2_instr;
    assign out_err   = r_s2_err;
    assign cnt_ok    = r_cnt_ok;
    assign cnt_err   = r_cnt_err;

endmodule
